controller: RTL and testbench
=============================

# controller

Multicycle control unit for the ARM32 core. Owns the program counter and instruction register, sequences every instruction through a seven-state FSM, and drives all control inputs of `datapath` and the RAM strobes. Sits directly upstream of `datapath`: consumes its `status_out` and produces every select, enable and address it uses.

## Interface
Parameters: none (encodings live in `controller_pkg`).

Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `instr`  in  32  instruction RAM read data, valid in FETCH_WAIT
- `status_out`  in  32  datapath flags, NZCV in [31:28]
- `PC`  out  32  program counter; instruction fetch address; also drives datapath `PC`
- `mem_rd`, `mem_wr`  out  1 each  data RAM read/write strobes (address = `datapath_out`, write data = `memory_out`)
- `sel_w_data`, `w_en1`  out  1 each  write-back source (1 = `ram_data2`) / port-1 write enable
- `w_addr1`  out  4  write-back register
- `A_addr`, `B_addr`, `shift_addr`  out  4 each  register read addresses
- `en_A`, `en_B`, `en_S`  out  1 each  operand latch enables
- `sel_shift`  out  1  1 = shift amount from register
- `shift_imme`  out  32  zero-extended instr[11:7]
- `shift_op`  out  2  instr[6:5]
- `sel_A`, `sel_B`, `sel_post_shift`  out  1 each  A = 0 / B = immediate / post-shift write (held 0)
- `imme_data`  out  32  zero-extended immediate
- `ALU_op`  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR
- `en_out1`, `en_out2`, `en_status1`, `en_status2`  out  1 each  datapath output/status stage enables
- `w_en2`, `w_addr2`  out  1/4  held 0

## Operation
- States: FETCH → FETCH_WAIT → DECODE → EXECUTE → MEMORY → [MEMORY_WAIT] → WRITE_BACK → FETCH.
- FETCH: `PC` presented to instruction RAM. FETCH_WAIT: IR ← `instr` at edge.
- DECODE: evaluate cond IR[31:28] against `status_out[31:28]` (ARM codes 0000–1101, 1110 always, 1111 never). Fail, or unsupported class → PC += 4, go FETCH. Else `en_A`=`en_B`=`en_S`=1; `A_addr`=Rn, `B_addr`=Rm (DP) or Rd (LDR/STR), `shift_addr`=Rs, `sel_shift`=IR[4].
- Supported: DP AND/EOR/SUB/ADD/ORR/MOV/CMP (opcodes 0000/0001/0010/0100/1100/1101/1010); LDR/STR immediate offset, pre-indexed, no writeback; B (L bit ignored). Everything else, including multiply pattern IR[7:4]=1001, is unsupported.
- EXECUTE: `en_out1`=1; `en_status1`=S (CMP forces 1, LDR/STR 0). DP: `sel_B`=IR[25], `imme_data`={24'b0,IR[7:0]} (rotate ignored), MOV → `sel_A`=1 + ADD, CMP → SUB. LDR/STR: `sel_B`=1, `imme_data`={20'b0,IR[11:0]}, ADD if U=1 else SUB. B: PC ← PC + 8 + (sext(IR[23:0]) << 2), go FETCH.
- MEMORY: `en_out2`=1, `en_status2`=`en_status1` value of EXECUTE; LDR `mem_rd`=1, STR `mem_wr`=1; LDR/STR → MEMORY_WAIT, DP → WRITE_BACK. MEMORY_WAIT: no strobes.
- WRITE_BACK: DP except CMP: `w_en1`=1, `w_addr1`=Rd, `sel_w_data`=0; LDR: `sel_w_data`=1, `w_en1`=1; STR/CMP: none. PC += 4, go FETCH.
- PC arithmetic modulo 2^32.

## Timing
- All outputs registered-state Moore decodes of state + IR; not listed = 0 in that state.
- Reset: state FETCH, PC = 0, IR = 0, every strobe/enable 0, all address/data outputs 0; asserting `rst_n` mid-instruction aborts immediately, no partial write or RAM strobe survives.
- Cycles per instruction: DP 6, LDR/STR 7, B 4, condition-fail/unsupported 3.
- Flags seen in DECODE are those committed by the previous instruction's MEMORY state.

## Structure
- `controller_pkg`: state enum (3-bit), ALU_op constants, ARM opcode and cond constants.
- One sub-module: `cond_eval` (combinational, cond + NZCV → pass).

## Test plan
- Reset: `rst_n`=0 then 1 → PC=0, state FETCH, all enables 0.
- ADD r3,r1,r2 (0xE0813002) → DECODE A_addr=1, B_addr=2; EXECUTE ALU_op=000, sel_B=0; WRITE_BACK w_en1=1, w_addr1=3; PC 0→4 after 6 cycles.
- MOVEQ r0,#5 (0x03A00005): Z=0 → no w_en1, PC+4 after 3 cycles; Z=1 → sel_A=1, sel_B=1, imme_data=5, w_en1=1, w_addr1=0.
- LDR r4,[r1,#8] (0xE5914008) → ALU_op=000, imme_data=8, mem_rd in MEMORY, WRITE_BACK sel_w_data=1, w_addr1=4; STR r4,[r1,#-4] (0xE5014004) → ALU_op=001, B_addr=4, mem_wr=1, no w_en1.
- B . (0xEAFFFFFE) at PC=0x10 → PC stays 0x10, 4-cycle loop.
- `rst_n` low during STR MEMORY → mem_wr drops same cycle, PC=0.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared encodings for the multicycle ARM32 controller: FSM states, ALU
// operation codes, ARM data-processing opcodes, condition codes and decode helpers.
package controller_pkg;

    typedef enum logic [2:0] {
        S_FETCH       = 3'd0,
        S_FETCH_WAIT  = 3'd1,
        S_DECODE      = 3'd2,
        S_EXECUTE     = 3'd3,
        S_MEMORY      = 3'd4,
        S_MEMORY_WAIT = 3'd5,
        S_WRITE_BACK  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_DP   = 2'd1,
        CLS_MEM  = 2'd2,
        CLS_BR   = 2'd3
    } iclass_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam logic [3:0] OPC_AND = 4'b0000;
    localparam logic [3:0] OPC_EOR = 4'b0001;
    localparam logic [3:0] OPC_SUB = 4'b0010;
    localparam logic [3:0] OPC_ADD = 4'b0100;
    localparam logic [3:0] OPC_CMP = 4'b1010;
    localparam logic [3:0] OPC_ORR = 4'b1100;
    localparam logic [3:0] OPC_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    function automatic logic dp_opcode_ok(input logic [3:0] opc);
        return (opc == OPC_AND) || (opc == OPC_EOR) || (opc == OPC_SUB) ||
               (opc == OPC_ADD) || (opc == OPC_ORR) || (opc == OPC_MOV) ||
               (opc == OPC_CMP);
    endfunction

    // Only word LDR/STR with immediate offset, pre-indexed, no writeback is handled.
    function automatic iclass_t classify(input logic [27:0] ir);
        iclass_t cls;
        cls = CLS_NONE;
        if (ir[27:26] == 2'b00) begin
            if (!(!ir[25] && ir[7:4] == 4'b1001) && dp_opcode_ok(ir[24:21]))
                cls = CLS_DP;
        end else if (ir[27:26] == 2'b01) begin
            if (!ir[25] && ir[24] && !ir[22] && !ir[21])
                cls = CLS_MEM;
        end else if (ir[27:25] == 3'b101) begin
            cls = CLS_BR;
        end
        return cls;
    endfunction

    function automatic logic [2:0] dp_alu_op(input logic [3:0] opc);
        logic [2:0] op;
        case (opc)
            OPC_AND: op = ALU_AND;
            OPC_EOR: op = ALU_EOR;
            OPC_SUB: op = ALU_SUB;
            OPC_CMP: op = ALU_SUB;
            OPC_ORR: op = ALU_ORR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/controller_cond_eval.sv
// ARM condition-code evaluator: decides whether an instruction executes
// given its cond field and the current NZCV flags.
module cond_eval
    import controller_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic flag_n, flag_z, flag_c, flag_v;

    assign flag_n = nzcv[3];
    assign flag_z = nzcv[2];
    assign flag_c = nzcv[1];
    assign flag_v = nzcv[0];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = flag_z;
            COND_NE: pass = !flag_z;
            COND_CS: pass = flag_c;
            COND_CC: pass = !flag_c;
            COND_MI: pass = flag_n;
            COND_PL: pass = !flag_n;
            COND_VS: pass = flag_v;
            COND_VC: pass = !flag_v;
            COND_HI: pass = flag_c && !flag_z;
            COND_LS: pass = !flag_c || flag_z;
            COND_GE: pass = (flag_n == flag_v);
            COND_LT: pass = (flag_n != flag_v);
            COND_GT: pass = !flag_z && (flag_n == flag_v);
            COND_LE: pass = flag_z || (flag_n != flag_v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/controller.sv
// Multicycle ARM32 control unit: owns PC and IR, sequences each instruction
// through the FSM and drives the datapath selects/enables and RAM strobes.
module controller
    import controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] status_out,
    output logic [31:0] PC,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        sel_w_data,
    output logic        w_en1,
    output logic [3:0]  w_addr1,
    output logic [3:0]  A_addr,
    output logic [3:0]  B_addr,
    output logic [3:0]  shift_addr,
    output logic        en_A,
    output logic        en_B,
    output logic        en_S,
    output logic        sel_shift,
    output logic [31:0] shift_imme,
    output logic [1:0]  shift_op,
    output logic        sel_A,
    output logic        sel_B,
    output logic        sel_post_shift,
    output logic [31:0] imme_data,
    output logic [2:0]  ALU_op,
    output logic        en_out1,
    output logic        en_out2,
    output logic        en_status1,
    output logic        en_status2,
    output logic        w_en2,
    output logic [3:0]  w_addr2
);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] ir_reg;

    iclass_t     cls;
    logic        cond_pass;
    logic [3:0]  opc, rn, rd, rs, rm;
    logic        is_load, status_en;
    logic [31:0] branch_target;
    logic        status_unused;

    assign status_unused = ^status_out[27:0];

    cond_eval u_cond_eval (
        .cond (ir_reg[31:28]),
        .nzcv (status_out[31:28]),
        .pass (cond_pass)
    );

    assign cls     = classify(ir_reg[27:0]);
    assign opc     = ir_reg[24:21];
    assign rn      = ir_reg[19:16];
    assign rd      = ir_reg[15:12];
    assign rs      = ir_reg[11:8];
    assign rm      = ir_reg[3:0];
    assign is_load = ir_reg[20];
    // Flags are written by S-suffixed DP ops and always by CMP; never by LDR/STR.
    assign status_en = (cls == CLS_DP) && (ir_reg[20] || opc == OPC_CMP);
    assign branch_target = pc_reg + 32'd8 + {{6{ir_reg[23]}}, ir_reg[23:0], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            pc_reg    <= 32'd0;
            ir_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (state_reg == S_FETCH_WAIT)
                ir_reg <= instr;
        end
    end

    assign PC = pc_reg;

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;
        sel_w_data     = 1'b0;
        w_en1          = 1'b0;
        w_addr1        = 4'd0;
        A_addr         = 4'd0;
        B_addr         = 4'd0;
        shift_addr     = 4'd0;
        en_A           = 1'b0;
        en_B           = 1'b0;
        en_S           = 1'b0;
        sel_shift      = 1'b0;
        shift_imme     = 32'd0;
        shift_op       = 2'b00;
        sel_A          = 1'b0;
        sel_B          = 1'b0;
        sel_post_shift = 1'b0;
        imme_data      = 32'd0;
        ALU_op         = ALU_ADD;
        en_out1        = 1'b0;
        en_out2        = 1'b0;
        en_status1     = 1'b0;
        en_status2     = 1'b0;
        w_en2          = 1'b0;
        w_addr2        = 4'd0;

        case (state_reg)
            S_FETCH: state_next = S_FETCH_WAIT;

            S_FETCH_WAIT: state_next = S_DECODE;

            S_DECODE: begin
                if (!cond_pass || cls == CLS_NONE) begin
                    pc_next    = pc_reg + 32'd4;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_EXECUTE;
                    // Branches need no register operands.
                    if (cls != CLS_BR) begin
                        en_A       = 1'b1;
                        en_B       = 1'b1;
                        en_S       = 1'b1;
                        A_addr     = rn;
                        B_addr     = (cls == CLS_MEM) ? rd : rm;
                        shift_addr = rs;
                    end
                    if (cls == CLS_DP) begin
                        sel_shift  = ir_reg[4];
                        shift_imme = {27'd0, ir_reg[11:7]};
                        shift_op   = ir_reg[6:5];
                    end
                end
            end

            S_EXECUTE: begin
                en_out1 = 1'b1;
                case (cls)
                    CLS_BR: begin
                        pc_next    = branch_target;
                        state_next = S_FETCH;
                    end
                    CLS_DP: begin
                        en_status1 = status_en;
                        sel_B      = ir_reg[25];
                        imme_data  = {24'd0, ir_reg[7:0]};
                        ALU_op     = dp_alu_op(opc);
                        sel_A      = (opc == OPC_MOV);
                        shift_imme = {27'd0, ir_reg[11:7]};
                        shift_op   = ir_reg[6:5];
                        state_next = S_MEMORY;
                    end
                    CLS_MEM: begin
                        sel_B      = 1'b1;
                        imme_data  = {20'd0, ir_reg[11:0]};
                        ALU_op     = ir_reg[23] ? ALU_ADD : ALU_SUB;
                        state_next = S_MEMORY;
                    end
                    default: begin
                        pc_next    = pc_reg + 32'd4;
                        state_next = S_FETCH;
                    end
                endcase
            end

            S_MEMORY: begin
                en_out2    = 1'b1;
                en_status2 = status_en;
                if (cls == CLS_MEM) begin
                    mem_rd     = is_load;
                    mem_wr     = !is_load;
                    state_next = S_MEMORY_WAIT;
                end else begin
                    state_next = S_WRITE_BACK;
                end
            end

            S_MEMORY_WAIT: state_next = S_WRITE_BACK;

            S_WRITE_BACK: begin
                if (cls == CLS_DP && opc != OPC_CMP) begin
                    w_en1   = 1'b1;
                    w_addr1 = rd;
                end else if (cls == CLS_MEM && is_load) begin
                    w_en1      = 1'b1;
                    w_addr1    = rd;
                    sel_w_data = 1'b1;
                end
                pc_next    = pc_reg + 32'd4;
                state_next = S_FETCH;
            end

            default: state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: a table of single instructions, each run
// from FETCH back to FETCH, plus reset and mid-instruction-reset sequences.
module tb_controller;
    import controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] status_out;
    logic [31:0] PC;
    logic        mem_rd, mem_wr, sel_w_data, w_en1;
    logic [3:0]  w_addr1, A_addr, B_addr, shift_addr;
    logic        en_A, en_B, en_S, sel_shift;
    logic [31:0] shift_imme;
    logic [1:0]  shift_op;
    logic        sel_A, sel_B, sel_post_shift;
    logic [31:0] imme_data;
    logic [2:0]  ALU_op;
    logic        en_out1, en_out2, en_status1, en_status2, w_en2;
    logic [3:0]  w_addr2;

    controller dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .status_out(status_out), .PC(PC),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .sel_w_data(sel_w_data), .w_en1(w_en1),
        .w_addr1(w_addr1), .A_addr(A_addr), .B_addr(B_addr), .shift_addr(shift_addr),
        .en_A(en_A), .en_B(en_B), .en_S(en_S), .sel_shift(sel_shift),
        .shift_imme(shift_imme), .shift_op(shift_op), .sel_A(sel_A), .sel_B(sel_B),
        .sel_post_shift(sel_post_shift), .imme_data(imme_data), .ALU_op(ALU_op),
        .en_out1(en_out1), .en_out2(en_out2), .en_status1(en_status1),
        .en_status2(en_status2), .w_en2(w_en2), .w_addr2(w_addr2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr, nzcv, cycles, pc_next, en, a, b, alu;
        logic [31:0] sel_a, sel_b, imme, est, rd, wr, wen, waddr, selw;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_pc;

    logic [31:0] c_en, c_a, c_b, c_alu, c_sel_a, c_sel_b, c_imme, c_est;
    logic [31:0] c_rd, c_wr, c_wen, c_waddr, c_selw, c_cycles;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Precondition: called at a falling edge with the FSM in FETCH.
    task automatic run_instr(input int idx, input logic [31:0] ins, input logic [31:0] nzcv);
        logic done;
        instr      = ins;
        status_out = {nzcv[3:0], 28'd0};
        {c_en, c_a, c_b, c_alu, c_sel_a, c_sel_b, c_imme} = '0;
        {c_est, c_rd, c_wr, c_wen, c_waddr, c_selw} = '0;
        chk($sformatf("v%0d fetch_pc", idx), PC, exp_pc);
        c_cycles = 32'd1;
        done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dut.state_reg == S_FETCH) begin
                done = 1'b1;
                break;
            end
            c_cycles++;
            c_rd = c_rd | 32'(mem_rd);
            c_wr = c_wr | 32'(mem_wr);
            case (dut.state_reg)
                S_DECODE: begin
                    c_en = 32'(en_A & en_B & en_S);
                    c_a  = 32'(A_addr);
                    c_b  = 32'(B_addr);
                end
                S_EXECUTE: begin
                    c_alu   = 32'(ALU_op);
                    c_sel_a = 32'(sel_A);
                    c_sel_b = 32'(sel_B);
                    c_imme  = imme_data;
                    c_est   = 32'(en_status1);
                end
                S_WRITE_BACK: begin
                    c_wen   = 32'(w_en1);
                    c_waddr = 32'(w_addr1);
                    c_selw  = 32'(sel_w_data);
                end
                default: ;
            endcase
        end
        chk($sformatf("v%0d back_to_fetch", idx), 32'(done), 32'd1);
    endtask

    task automatic run_vec(input int i);
        run_instr(i, vecs[i].instr, vecs[i].nzcv);
        chk($sformatf("v%0d cycles", i), c_cycles, vecs[i].cycles);
        chk($sformatf("v%0d pc_next", i), PC, vecs[i].pc_next);
        chk($sformatf("v%0d en_ABS", i), c_en, vecs[i].en);
        chk($sformatf("v%0d A_addr", i), c_a, vecs[i].a);
        chk($sformatf("v%0d B_addr", i), c_b, vecs[i].b);
        chk($sformatf("v%0d ALU_op", i), c_alu, vecs[i].alu);
        chk($sformatf("v%0d sel_A", i), c_sel_a, vecs[i].sel_a);
        chk($sformatf("v%0d sel_B", i), c_sel_b, vecs[i].sel_b);
        chk($sformatf("v%0d imme_data", i), c_imme, vecs[i].imme);
        chk($sformatf("v%0d en_status1", i), c_est, vecs[i].est);
        chk($sformatf("v%0d mem_rd", i), c_rd, vecs[i].rd);
        chk($sformatf("v%0d mem_wr", i), c_wr, vecs[i].wr);
        chk($sformatf("v%0d w_en1", i), c_wen, vecs[i].wen);
        chk($sformatf("v%0d w_addr1", i), c_waddr, vecs[i].waddr);
        chk($sformatf("v%0d sel_w_data", i), c_selw, vecs[i].selw);
        $display("vec %0d instr=%08h nzcv=%0h cycles=%0d pc=%08h", i, vecs[i].instr,
                 vecs[i].nzcv, c_cycles, PC);
        exp_pc = vecs[i].pc_next;
    endtask

    initial begin
        //         instr        nzcv cyc pc   en a  b  alu sA sB imme  est rd wr wen wa sw
        vecs = '{
            '{32'hE0813002, 0, 6,  4, 1, 1, 2, 0, 0, 0, 'h02, 0, 0, 0, 1, 3, 0},  // ADD r3,r1,r2
            '{32'h03A00005, 0, 3,  8, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0},  // MOVEQ, Z=0
            '{32'h03A00005, 4, 6, 12, 1, 0, 5, 0, 1, 1, 'h05, 0, 0, 0, 1, 0, 0},  // MOVEQ, Z=1
            '{32'hE5914008, 0, 7, 16, 1, 1, 4, 0, 0, 1, 'h08, 0, 1, 0, 1, 4, 1},  // LDR r4,[r1,#8]
            '{32'hE5014004, 0, 7, 20, 1, 1, 4, 1, 0, 1, 'h04, 0, 0, 1, 0, 0, 0},  // STR r4,[r1,#-4]
            '{32'hE1510002, 0, 6, 24, 1, 1, 2, 1, 0, 0, 'h02, 1, 0, 0, 0, 0, 0},  // CMP r1,r2
            '{32'hE21650FF, 0, 6, 28, 1, 6,15, 2, 0, 1, 'hFF, 1, 0, 0, 1, 5, 0},  // ANDS r5,r6,#FF
            '{32'hE0010392, 0, 3, 32, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0},  // MUL unsupported
            '{32'h10813002, 4, 3, 36, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0},  // ADDNE, Z=1
            '{32'hC0287009, 9, 6, 40, 1, 8, 9, 4, 0, 0, 'h09, 0, 0, 0, 1, 7, 0},  // EORGT N=V=1
            '{32'hB1832004, 8, 6, 44, 1, 3, 4, 3, 0, 0, 'h04, 0, 0, 0, 1, 2, 0},  // ORRLT N=1
            '{32'hF0813002, 0, 3, 48, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0},  // NV never
            '{32'hEA000004, 0, 4, 72, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0},  // B +16
            '{32'hEB000000, 0, 4, 80, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0},  // BL, L ignored
            '{32'hEAFFFFEE, 0, 4, 16, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0},  // B back to 0x10
            '{32'hEAFFFFFE, 0, 4, 16, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0},  // B .
            '{32'hEAFFFFFE, 0, 4, 16, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0},  // B . again
            '{32'h20412003, 2, 6, 20, 1, 1, 3, 1, 0, 0, 'h03, 0, 0, 0, 1, 2, 0},  // SUBCS C=1
            '{32'h80412003, 6, 3, 24, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0},  // SUBHI C=1 Z=1
            '{32'hE7914002, 0, 3, 28, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0}   // LDR reg offset
        };

        rst_n      = 1'b0;
        instr      = 32'd0;
        status_out = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset PC", PC, 32'd0);
        chk("reset state", 32'(dut.state_reg), 32'(S_FETCH));
        chk("reset enables", 32'({w_en1, mem_rd, mem_wr, en_A, en_B, en_S, en_out1,
                                   en_out2, en_status1, en_status2}), 32'd0);
        chk("reset addrs", 32'({w_addr1, A_addr, B_addr, shift_addr}), 32'd0);
        chk("reset imme", imme_data, 32'd0);
        rst_n  = 1'b1;
        exp_pc = 32'd0;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Abort a STR while its write strobe is active.
        instr      = 32'hE5014004;
        status_out = 32'd0;
        for (int k = 0; k < 10 && dut.state_reg != S_MEMORY; k++) @(negedge clk);
        chk("midrst reached MEMORY", 32'(dut.state_reg), 32'(S_MEMORY));
        chk("midrst mem_wr before", 32'(mem_wr), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst mem_wr after", 32'(mem_wr), 32'd0);
        chk("midrst en_out2 after", 32'(en_out2), 32'd0);
        chk("midrst PC", PC, 32'd0);
        $display("midrst: mem_wr=%0b PC=%08h", mem_wr, PC);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 32'd0;
        run_vec(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
